// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined floating-point multiplier.
// The optional status flags are enabled with FP_MULT_FLAGS_EN.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_NAN
  } fp_class_e;

  localparam int FLAG_W         = 4;
  localparam int FLAG_INEXACT   = 0;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_INVALID   = 3;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic int fp_emax(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Final-stage combinational rounding (nearest-even), range check and packing.
// Flag outputs exist only when FP_MULT_FLAGS_EN is defined.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic [MAN_W-1:0]       i_man,
  input  logic                   i_guard,
  input  logic                   i_sticky,
  input  logic [EXP_W+1:0]       i_exp,
  input  logic                   i_sign,
  input  fp_class_e              i_cls,
  output logic [EXP_W+MAN_W:0]   o_word
`ifdef FP_MULT_FLAGS_EN
  ,
  output logic [FLAG_W-1:0]      o_flags
`endif
);

  localparam int EW   = EXP_W + 2;
  localparam int EMAX = fp_emax(EXP_W);

  logic           w_rnd_up;
  logic [MAN_W:0] w_sum;
  logic [EW-1:0]  w_exp_r;
  logic           w_ovf;
  logic           w_unf;

  assign w_rnd_up = i_guard & (i_man[0] | i_sticky);
  assign w_sum    = {1'b0, i_man} + {{MAN_W{1'b0}}, w_rnd_up};
  // A carry out leaves the mantissa at zero, so only the exponent needs bumping.
  assign w_exp_r  = i_exp + {{(EW-1){1'b0}}, w_sum[MAN_W]};
  assign w_ovf    = !w_exp_r[EW-1] && (w_exp_r >= EW'(EMAX));
  assign w_unf    = w_exp_r[EW-1] || (w_exp_r == '0);

  always_comb begin
    o_word = '0;
`ifdef FP_MULT_FLAGS_EN
    o_flags = '0;
`endif
    case (i_cls)
      FP_NAN: begin
        o_word = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FP_MULT_FLAGS_EN
        o_flags[FLAG_INVALID] = 1'b1;
`endif
      end
      FP_INF:  o_word = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      FP_ZERO: o_word = {i_sign, {(EXP_W+MAN_W){1'b0}}};
      default: begin
        if (w_ovf) begin
          o_word = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_MULT_FLAGS_EN
          o_flags[FLAG_OVERFLOW] = 1'b1;
          o_flags[FLAG_INEXACT]  = 1'b1;
`endif
        end else if (w_unf) begin
          o_word = {i_sign, {(EXP_W+MAN_W){1'b0}}};
`ifdef FP_MULT_FLAGS_EN
          o_flags[FLAG_UNDERFLOW] = 1'b1;
          o_flags[FLAG_INEXACT]   = 1'b1;
`endif
        end else begin
          o_word = {i_sign, w_exp_r[EXP_W-1:0], w_sum[MAN_W-1:0]};
`ifdef FP_MULT_FLAGS_EN
          o_flags[FLAG_INEXACT] = i_guard | i_sticky;
`endif
        end
      end
    endcase
  end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage floating-point multiplier with valid/ready on both sides.
// Define FP_MULT_FLAGS_EN to add the {invalid, overflow, underflow, inexact} flags port.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EXP_W+MAN_W:0]  din_a,
  input  logic [EXP_W+MAN_W:0]  din_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EXP_W+MAN_W:0]  dout
`ifdef FP_MULT_FLAGS_EN
  ,
  output logic [FLAG_W-1:0]     flags
`endif
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int BIAS = fp_bias(EXP_W);

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
    fp_class_e c;
    if (e == '0)        c = FP_ZERO;
    else if (e != '1)   c = FP_NORM;
    else if (m == '0)   c = FP_INF;
    else                c = FP_NAN;
    return c;
  endfunction

  logic            w_rdy1, w_rdy2, w_rdy3;
  logic            r_v1, r_v2, r_v3;

  fp_class_e       w_cls_a, w_cls_b, w_cls1;
  logic [PW-1:0]   w_prod;
  logic [EW-1:0]   w_exp1;

  fp_class_e       r_cls1;
  logic            r_sign1;
  logic [PW-1:0]   r_p1;
  logic [EW-1:0]   r_e1;

  logic            w_hi;
  logic [MAN_W-1:0] w_man2;
  logic            w_g2, w_s2;
  logic [EW-1:0]   w_exp2;

  fp_class_e       r_cls2;
  logic            r_sign2;
  logic [MAN_W-1:0] r_man2;
  logic            r_g2, r_s2;
  logic [EW-1:0]   r_e2;

  logic [W-1:0]    w_word3;
  logic [W-1:0]    r_dout;

  // Each stage may load when empty or when the stage below it is moving.
  assign w_rdy3    = !r_v3 || out_ready;
  assign w_rdy2    = !r_v2 || w_rdy3;
  assign w_rdy1    = !r_v1 || w_rdy2;
  assign in_ready  = !rst && w_rdy1;
  assign out_valid = r_v3;
  assign dout      = r_dout;

  assign w_cls_a = classify(din_a[W-2 -: EXP_W], din_a[MAN_W-1:0]);
  assign w_cls_b = classify(din_b[W-2 -: EXP_W], din_b[MAN_W-1:0]);

  always_comb begin
    w_cls1 = FP_NORM;
    if (w_cls_a == FP_NAN || w_cls_b == FP_NAN ||
        (w_cls_a == FP_INF && w_cls_b == FP_ZERO) ||
        (w_cls_a == FP_ZERO && w_cls_b == FP_INF))
      w_cls1 = FP_NAN;
    else if (w_cls_a == FP_INF || w_cls_b == FP_INF)
      w_cls1 = FP_INF;
    else if (w_cls_a == FP_ZERO || w_cls_b == FP_ZERO)
      w_cls1 = FP_ZERO;
  end

  assign w_prod = {{(MAN_W+1){1'b0}}, 1'b1, din_a[MAN_W-1:0]} *
                  {{(MAN_W+1){1'b0}}, 1'b1, din_b[MAN_W-1:0]};
  assign w_exp1 = {2'b00, din_a[W-2 -: EXP_W]} + {2'b00, din_b[W-2 -: EXP_W]} - EW'(BIAS);

  // Product lies in [1,4); a set MSB means the value is in [2,4).
  assign w_hi   = r_p1[PW-1];
  assign w_man2 = w_hi ? r_p1[PW-2 -: MAN_W] : r_p1[PW-3 -: MAN_W];
  assign w_g2   = w_hi ? r_p1[PW-2-MAN_W] : r_p1[PW-3-MAN_W];
  assign w_s2   = w_hi ? |r_p1[PW-3-MAN_W:0] : |r_p1[PW-4-MAN_W:0];
  assign w_exp2 = r_e1 + {{(EW-1){1'b0}}, w_hi};

`ifdef FP_MULT_FLAGS_EN
  logic [FLAG_W-1:0] w_flags3;
  logic [FLAG_W-1:0] r_flags;
  assign flags = r_flags;
`endif

  fp_round_pack #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round_pack (
    .i_man    (r_man2),
    .i_guard  (r_g2),
    .i_sticky (r_s2),
    .i_exp    (r_e2),
    .i_sign   (r_sign2),
    .i_cls    (r_cls2),
    .o_word   (w_word3)
`ifdef FP_MULT_FLAGS_EN
    ,
    .o_flags  (w_flags3)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
      r_v3    <= 1'b0;
      r_cls1  <= FP_ZERO;
      r_sign1 <= 1'b0;
      r_p1    <= '0;
      r_e1    <= '0;
      r_cls2  <= FP_ZERO;
      r_sign2 <= 1'b0;
      r_man2  <= '0;
      r_g2    <= 1'b0;
      r_s2    <= 1'b0;
      r_e2    <= '0;
      r_dout  <= '0;
`ifdef FP_MULT_FLAGS_EN
      r_flags <= '0;
`endif
    end else begin
      if (w_rdy1) begin
        r_v1 <= in_valid;
        if (in_valid) begin
          r_cls1  <= w_cls1;
          r_sign1 <= din_a[W-1] ^ din_b[W-1];
          r_p1    <= w_prod;
          r_e1    <= w_exp1;
        end
      end
      if (w_rdy2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_cls2  <= r_cls1;
          r_sign2 <= r_sign1;
          r_man2  <= w_man2;
          r_g2    <= w_g2;
          r_s2    <= w_s2;
          r_e2    <= w_exp2;
        end
      end
      // Output registers hold steady while the consumer stalls.
      if (w_rdy3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_dout  <= w_word3;
`ifdef FP_MULT_FLAGS_EN
          r_flags <= w_flags3;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe (binary16 default); flag checks compile in with FP_MULT_FLAGS_EN.
module tb_fp_mult_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] din_a = 16'h0;
  logic [15:0] din_b = 16'h0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] dout;
`ifdef FP_MULT_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] st_a[$], st_b[$];
  logic [15:0] res_d[$];
  logic [3:0]  res_f[$];
  int          t_acc[$], t_out[$];

  always #5 clk = ~clk;

  fp_mult_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din_a     (din_a),
    .din_b     (din_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
`ifdef FP_MULT_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  // Reference: exact integer product, rounded by remainder comparison against one half ulp.
  function automatic logic [19:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, e, sh;
    logic s;
    bit an, bn, ai, bi, az, bz;
    longint p, keep, rem, half;
    logic [3:0] fl;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = int'(a[9:0]);   mb = int'(b[9:0]);
    s  = a[15] ^ b[15];
    an = (ea == 31) && (ma != 0); bn = (eb == 31) && (mb != 0);
    ai = (ea == 31) && (ma == 0); bi = (eb == 31) && (mb == 0);
    az = (ea == 0);               bz = (eb == 0);
    if (an || bn || (ai && bz) || (bi && az)) return {4'b1000, 16'h7E00};
    if (ai || bi) return {4'b0000, s, 5'h1F, 10'h000};
    if (az || bz) return {4'b0000, s, 15'h0000};
    p  = longint'(1024 + ma) * longint'(1024 + mb);
    e  = ea + eb - 15;
    sh = 10;
    if (p >= 64'd2097152) begin e++; sh = 11; end
    keep = p >> sh;
    rem  = p - (keep << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep++;
    if (keep >= 2048) begin keep = keep >> 1; e++; end
    if (e >= 31) return {4'b0101, s, 5'h1F, 10'h000};
    if (e <= 0)  return {4'b0011, s, 15'h0000};
    fl = {3'b000, rem != 0};
    return {fl, s, 5'(e), 10'(keep)};
  endfunction

  function automatic logic [15:0] rand_op(input bit normal_only);
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    int sel;
    s   = 1'($urandom_range(0, 1));
    m   = 10'($urandom_range(0, 1023));
    sel = normal_only ? 9 : int'($urandom_range(0, 9));
    case (sel)
      0: e = 5'd0;
      1: begin e = 5'd31; m = 10'd0; end
      2: begin e = 5'd31; if (m == 10'd0) m = 10'd1; end
      3: e = 5'($urandom_range(1, 6));
      4: e = 5'($urandom_range(25, 30));
      default: e = 5'($urandom_range(8, 22));
    endcase
    return {s, e, m};
  endfunction

  // Drives one cycle from a falling edge, samples handshake 1 time unit later.
  task automatic drive_cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                             input logic ordy, output logic acc, output logic drn,
                             output logic ir, output logic ov, output logic [15:0] d,
                             output logic [3:0] f, output int t);
    in_valid = iv; din_a = a; din_b = b; out_ready = ordy;
    #1;
    ir  = in_ready;
    ov  = out_valid;
    acc = iv && in_ready;
    drn = out_valid && ordy;
    d   = dout;
`ifdef FP_MULT_FLAGS_EN
    f = flags;
`else
    f = 4'h0;
`endif
    t = cyc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_stream(input int n, input bit rnd_in, input bit rnd_out, output bit timeout);
    int idx, budget, t;
    logic acc, drn, ir, ov, iv, orr;
    logic [15:0] d, a, b;
    logic [3:0] f;
    res_d.delete(); res_f.delete(); t_acc.delete(); t_out.delete();
    idx = 0; budget = 0;
    while (res_d.size() < n && budget < 4000) begin
      iv  = (idx < n) && (!rnd_in || ($urandom_range(0, 3) != 0));
      orr = !rnd_out || ($urandom_range(0, 2) != 0);
      a   = (idx < n) ? st_a[idx] : 16'h0;
      b   = (idx < n) ? st_b[idx] : 16'h0;
      drive_cycle(iv, a, b, orr, acc, drn, ir, ov, d, f, t);
      if (acc) begin t_acc.push_back(t); idx++; end
      if (drn) begin res_d.push_back(d); res_f.push_back(f); t_out.push_back(t); end
      budget++;
    end
    in_valid = 1'b0;
    timeout = (res_d.size() != n);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; din_a = 16'h3C00; din_b = 16'h3C00; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", dout); end
`ifdef FP_MULT_FLAGS_EN
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
`endif
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_directed();
    logic [15:0] va[10], vb[10], vd[10];
    logic [3:0]  vf[10];
    bit to;
    va = '{16'h3C00, 16'h4000, 16'h3C01, 16'h0000, 16'h0123, 16'h7BFF, 16'h0400, 16'h7C00, 16'h7D00, 16'hFC00};
    vb = '{16'h3E00, 16'h4200, 16'h3C01, 16'hC000, 16'h3C00, 16'h4000, 16'h0400, 16'h0000, 16'h3C00, 16'h4000};
    vd = '{16'h3E00, 16'h4600, 16'h3C02, 16'h8000, 16'h0000, 16'h7C00, 16'h0000, 16'h7E00, 16'h7E00, 16'hFC00};
    vf = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0101, 4'b0011, 4'b1000, 4'b1000, 4'b0000};
    st_a.delete(); st_b.delete();
    for (int i = 0; i < 10; i++) begin st_a.push_back(va[i]); st_b.push_back(vb[i]); end
    run_stream(10, 1'b0, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL directed_timeout: got %0d results want 10", res_d.size()); end
    for (int i = 0; i < res_d.size(); i++) begin
      checks++;
      if (res_d[i] !== vd[i]) begin errors++; $display("FAIL directed_dout[%0d]: got %h want %h", i, res_d[i], vd[i]); end
`ifdef FP_MULT_FLAGS_EN
      checks++;
      if (res_f[i] !== vf[i]) begin errors++; $display("FAIL directed_flags[%0d]: got %b want %b", i, res_f[i], vf[i]); end
`endif
      checks++;
      if (t_out[i] - t_acc[i] != 3) begin errors++; $display("FAIL directed_latency[%0d]: got %0d want 3", i, t_out[i] - t_acc[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] exp_v;
    bit to;
    st_a.delete(); st_b.delete();
    for (int i = 0; i < 40; i++) begin st_a.push_back(rand_op(1'b1)); st_b.push_back(rand_op(1'b1)); end
    run_stream(40, 1'b0, 1'b0, to);
    checks++; if (to) begin errors++; $display("FAIL b2b_timeout: got %0d results want 40", res_d.size()); end
    for (int i = 0; i < res_d.size(); i++) begin
      exp_v = ref_mul(st_a[i], st_b[i]);
      checks++;
      if (res_d[i] !== exp_v[15:0]) begin errors++; $display("FAIL b2b_dout[%0d]: %h*%h got %h want %h", i, st_a[i], st_b[i], res_d[i], exp_v[15:0]); end
      checks++;
      if (t_acc[i] - t_acc[0] != i) begin errors++; $display("FAIL b2b_throughput[%0d]: accept gap got %0d want %0d", i, t_acc[i] - t_acc[0], i); end
      checks++;
      if (t_out[i] - t_acc[i] != 3) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want 3", i, t_out[i] - t_acc[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] pa[5], pb[5];
    logic [15:0] got_d[$];
    logic [3:0]  got_f[$];
    logic [15:0] d, hold_d;
    logic [3:0]  f, hold_f;
    logic [19:0] exp_v;
    logic acc, drn, ir, ov, last_ir;
    bit have_hold;
    int idx, k, t, budget;
    for (int i = 0; i < 5; i++) begin pa[i] = rand_op(1'b1); pb[i] = rand_op(1'b1); end
    idx = 0; have_hold = 0; last_ir = 1'b1; hold_d = 16'h0; hold_f = 4'h0;
    for (int i = 0; i < 6; i++) begin
      k = (idx < 5) ? idx : 4;
      drive_cycle(idx < 5, pa[k], pb[k], 1'b0, acc, drn, ir, ov, d, f, t);
      if (acc) idx++;
      if (ov) begin
        if (!have_hold) begin hold_d = d; hold_f = f; have_hold = 1; end
        else begin
          checks++;
          if (d !== hold_d) begin errors++; $display("FAIL bp_dout_stable: got %h want %h", d, hold_d); end
`ifdef FP_MULT_FLAGS_EN
          checks++;
          if (f !== hold_f) begin errors++; $display("FAIL bp_flags_stable: got %b want %b", f, hold_f); end
`endif
        end
      end
      last_ir = ir;
    end
    checks++; if (idx != 3) begin errors++; $display("FAIL bp_accepts: got %0d want 3", idx); end
    checks++; if (last_ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", last_ir); end
    checks++; if (!have_hold) begin errors++; $display("FAIL bp_out_valid: got 0 want 1 while stalled"); end
    k = (idx < 5) ? idx : 4;
    drive_cycle(idx < 5, pa[k], pb[k], 1'b1, acc, drn, ir, ov, d, f, t);
    checks++;
    if (!(acc && drn)) begin errors++; $display("FAIL bp_full_accept_drain: got acc=%b drn=%b want 1 1", acc, drn); end
    if (acc) idx++;
    if (drn) begin got_d.push_back(d); got_f.push_back(f); end
    budget = 0;
    while (got_d.size() < 5 && budget < 40) begin
      k = (idx < 5) ? idx : 4;
      drive_cycle(idx < 5, pa[k], pb[k], 1'b1, acc, drn, ir, ov, d, f, t);
      if (acc) idx++;
      if (drn) begin got_d.push_back(d); got_f.push_back(f); end
      budget++;
    end
    in_valid = 1'b0;
    checks++; if (got_d.size() != 5) begin errors++; $display("FAIL bp_count: got %0d want 5", got_d.size()); end
    for (int i = 0; i < got_d.size(); i++) begin
      exp_v = ref_mul(pa[i], pb[i]);
      checks++;
      if (got_d[i] !== exp_v[15:0]) begin errors++; $display("FAIL bp_dout[%0d]: got %h want %h", i, got_d[i], exp_v[15:0]); end
`ifdef FP_MULT_FLAGS_EN
      checks++;
      if (got_f[i] !== exp_v[19:16]) begin errors++; $display("FAIL bp_flags[%0d]: got %b want %b", i, got_f[i], exp_v[19:16]); end
`endif
    end
  endtask

  task automatic test_reset_mid();
    logic acc, drn, ir, ov, accepted, done;
    logic [15:0] d, got;
    logic [3:0] f;
    int t, t0, t1, budget;
    bit seen;
    drive_cycle(1'b1, 16'h4000, 16'h4200, 1'b1, acc, drn, ir, ov, d, f, t);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rstmid_accept0: got %b want 1", acc); end
    drive_cycle(1'b1, 16'h3C00, 16'h3E00, 1'b1, acc, drn, ir, ov, d, f, t);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL rstmid_accept1: got %b want 1", acc); end
    rst = 1'b1;
    drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, acc, drn, ir, ov, d, f, t);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, acc, drn, ir, ov, d, f, t);
      if (ov) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_flush: got out_valid=1 want 0 after reset"); end
    accepted = 0; done = 0; t0 = 0; t1 = 0; got = 16'h0; budget = 0;
    while (!done && budget < 12) begin
      drive_cycle(!accepted, 16'h3C01, 16'h3C01, 1'b1, acc, drn, ir, ov, d, f, t);
      if (acc) begin accepted = 1; t0 = t; end
      if (drn) begin done = 1; t1 = t; got = d; end
      budget++;
    end
    in_valid = 1'b0;
    checks++; if (!done) begin errors++; $display("FAIL rstmid_timeout: got no result want 1"); end
    checks++; if (got !== 16'h3C02) begin errors++; $display("FAIL rstmid_dout: got %h want 3c02", got); end
    checks++; if (t1 - t0 != 3) begin errors++; $display("FAIL rstmid_latency: got %0d want 3", t1 - t0); end
  endtask

  task automatic test_random();
    logic [19:0] exp_v;
    logic acc, drn, ir, ov;
    logic [15:0] d;
    logic [3:0] f;
    int t;
    bit to, extra;
    st_a.delete(); st_b.delete();
    for (int i = 0; i < 300; i++) begin st_a.push_back(rand_op(1'b0)); st_b.push_back(rand_op(1'b0)); end
    run_stream(300, 1'b1, 1'b1, to);
    checks++; if (to) begin errors++; $display("FAIL rand_timeout: got %0d results want 300", res_d.size()); end
    for (int i = 0; i < res_d.size(); i++) begin
      exp_v = ref_mul(st_a[i], st_b[i]);
      checks++;
      if (res_d[i] !== exp_v[15:0]) begin errors++; $display("FAIL rand_dout[%0d]: %h*%h got %h want %h", i, st_a[i], st_b[i], res_d[i], exp_v[15:0]); end
`ifdef FP_MULT_FLAGS_EN
      checks++;
      if (res_f[i] !== exp_v[19:16]) begin errors++; $display("FAIL rand_flags[%0d]: %h*%h got %b want %b", i, st_a[i], st_b[i], res_f[i], exp_v[19:16]); end
`endif
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 16'h0, 16'h0, 1'b1, acc, drn, ir, ov, d, f, t);
      if (drn) extra = 1;
    end
    checks++; if (extra) begin errors++; $display("FAIL rand_extra_output: got extra result want none"); end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Parametrised, pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes on both sides. It replaces the single-cycle half-precision multiplier in the neural-network datapath. Its default configuration is binary16, and exponent and mantissa widths are generic. It adds round-to-nearest-even, special-value handling (zero, Inf, NaN), overflow saturation and backpressure-safe 3-stage buffering between the MAC array feeders and the accumulators.

## Interface
- EXP_W, 5, exponent field width (≥3)
- MAN_W, 10, stored mantissa field width (≥2); word width W = 1+EXP_W+MAN_W
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts pair this cycle
- din_a, din_b  in  W  operands {sign, exp, man}
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result this cycle
- dout  out  W  product
- flags  out  4  {invalid, overflow, underflow, inexact}; present only with FP_MULT_FLAGS_EN

## Operation
- BIAS = 2^(EXP_W-1)-1. EMAX = 2^EXP_W-1.
- Classification: exp=0 → zero (subnormals flushed to zero, mantissa ignored). exp=EMAX, man=0 → Inf. exp=EMAX, man≠0 → NaN.
- Result sign = sign_a ^ sign_b in all cases except NaN.
- NaN in, or Inf×zero → canonical qNaN: sign 0, exp EMAX, man MSB 1, rest 0; invalid=1.
- Inf×(nonzero, non-NaN) → Inf. Zero×finite → signed zero.
- Finite path:
  - P = {1,man_a}×{1,man_b}, 2·MAN_W+2 bits.
  - E = exp_a+exp_b-BIAS, computed signed in EXP_W+2 bits.
  - If P MSB = 1: E+1, shift right by one.
  - Keep MAN_W bits. Guard is the next bit; sticky is the OR of the rest.
  - Round to nearest, ties to even.
  - If rounding carries out of the mantissa: mantissa becomes 0, E+1.
- After rounding:
  - E ≥ EMAX → signed Inf; overflow=1, inexact=1.
  - E ≤ 0 → signed zero; underflow=1, inexact=1.
  - Otherwise inexact = guard|sticky.
- Pipeline stages:
  - S1: classify, mantissa product, raw exponent sum.
  - S2: normalise, guard/sticky.
  - S3: round, overflow/underflow, pack.
- Each stage has a valid bit. A stage loads when it is empty or its downstream stage advances. Bubbles collapse.
- in_ready = S1 empty or S1 advancing. out_valid = S3 valid. S3 advances on out_valid & out_ready.
- Results leave strictly in acceptance order. None dropped, none duplicated.

## Timing
- Latency: a pair accepted in cycle N gives out_valid in cycle N+3 when out_ready has been high throughout.
- Throughput: one result per cycle.
- Reset values: all stage valid bits 0, out_valid 0, dout 0, flags 0. in_ready is 1 from the first cycle after rst deasserts.
- in_ready is 0 during reset.
- Reset mid-operation discards all in-flight operands. No output appears for them.
- With out_ready low, up to 3 pairs are held; in_ready then drops to 0.
- dout and flags stay stable while out_valid=1 and out_ready=0.
- Simultaneous input accept and output drain when full: both occur in the same cycle; occupancy is unchanged.
- in_valid with in_ready=0: operands are ignored, and the source must hold them.

## Configuration
- FP_MULT_FLAGS_EN defined: the flags port exists. Flags are carried through the pipeline alongside dout and share its valid/stability rules.
- Not defined: the flags port and all flag logic are absent. dout behaviour is identical.

## Structure
- Package fp_pkg:
  - fp_class_e enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}
  - localparam functions for BIAS and EMAX from EXP_W
  - flag bit index constants
- Sub-module fp_round_pack (S3 combinational): inputs are normalised mantissa, guard, sticky, signed exponent, sign and class; outputs are the packed word and flags.
- fp_mult_pipe holds the S1/S2 logic, all stage registers and the handshake.

## Test plan
- 0x3C00×0x3E00 and 0x4000×0x4200, out_ready=1 → 0x3E00 then 0x4600, each 3 cycles after accept, flags 0.
- 0x3C01×0x3C01 → 0x3C02, inexact=1. 0x0000×0xC000 → 0x8000. 0x0123×0x3C00 (subnormal) → 0x0000.
- 0x7BFF×0x4000 → 0x7C00, overflow=1. 0x0400×0x0400 → 0x0000, underflow=1.
- 0x7C00×0x0000 → 0x7E00, invalid=1. 0x7D00×0x3C00 → 0x7E00. 0xFC00×0x4000 → 0xFC00.
- Backpressure: 5 back-to-back pairs, out_ready low for 6 cycles → in_ready low after 3 accepts. All 5 results emerge in order once out_ready is high; dout is stable while stalled.
- rst pulsed with 2 pairs in flight → no out_valid for them. The next pair gives a correct result 3 cycles after accept.
